// File: rtl/mult_datapath.sv
// ----------------------------------------------------------------------------
// mult_datapath
//   Shift-add multiplier datapath driven by an external CONTROL sequencer.
//   Holds the multiplicand, a (2*WIDTH+1)-bit accumulator whose low half
//   starts as the multiplier, and a bit counter. It returns the current
//   multiplier bit (M) and the last-bit flag (K) to CONTROL, and registers
//   the finished product together with a valid flag.
//
// Ports
//   Clk        in   1        system clock, rising edge
//   reset_n    in   1        asynchronous reset, active low
//   Load       in   1        capture operands, clear counter and valid flag
//   Ad         in   1        add multiplicand into upper accumulator half
//   Sh         in   1        shift accumulator right, count one bit
//   Done       in   1        capture accumulator into Product, set ProdValid
//   Mplier     in   WIDTH    multiplier operand, sampled on Load
//   Mcand      in   WIDTH    multiplicand operand, sampled on Load
//   M          out  1        accumulator bit 0 (combinational)
//   K          out  1        counter at its last value (combinational)
//   Product    out  2*WIDTH  registered result
//   ProdValid  out  1        Product holds a completed result
// ----------------------------------------------------------------------------
module mult_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 reset_n,
  input  logic                 Load,
  input  logic                 Ad,
  input  logic                 Sh,
  input  logic                 Done,
  input  logic [WIDTH-1:0]     Mplier,
  input  logic [WIDTH-1:0]     Mcand,
  output logic                 M,
  output logic                 K,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 ProdValid
);

  localparam int unsigned AW = 2 * WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [AW-1:0]    r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_product;
  logic             r_prod_valid;

  logic [SW-1:0]    w_sum;
  logic [AW-1:0]    w_acc_add;
  logic [AW-1:0]    w_acc_src;
  logic [AW-1:0]    w_acc_shifted;
  logic [AW-1:0]    w_acc_next;
  logic [WIDTH-1:0] w_mcand_next;
  logic [CW-1:0]    w_cnt_inc;
  logic [CW-1:0]    w_cnt_next;
  logic [PW-1:0]    w_product_next;
  logic             w_prod_valid_next;
  logic             w_cnt_last;

  // Upper-half add; the previous carry bit is dropped, the new carry lands in ACC[2W].
  assign w_sum     = SW'(r_acc[PW-1:WIDTH]) + SW'(r_mcand);
  assign w_acc_add = {w_sum, r_acc[WIDTH-1:0]};

  // With Ad and Sh together the add result feeds the shifter in the same cycle.
  assign w_acc_src     = Ad ? w_acc_add : r_acc;
  assign w_acc_shifted = w_acc_src >> 1;

  // Counter wraps explicitly so non-power-of-two widths still cycle through WIDTH states.
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_cnt_inc  = w_cnt_last ? '0 : r_cnt + CW'(1);

  // Next-state selection: Load overrides everything, Done is independent of Ad/Sh.
  always_comb begin
    w_acc_next        = r_acc;
    w_mcand_next      = r_mcand;
    w_cnt_next        = r_cnt;
    w_product_next    = r_product;
    w_prod_valid_next = r_prod_valid;

    if (Load) begin
      w_acc_next        = AW'(Mplier);
      w_mcand_next      = Mcand;
      w_cnt_next        = '0;
      w_prod_valid_next = 1'b0;
    end else begin
      if (Sh) begin
        w_acc_next = w_acc_shifted;
        w_cnt_next = w_cnt_inc;
      end else if (Ad) begin
        w_acc_next = w_acc_add;
      end

      // Captures the accumulator as it was before any same-cycle add/shift.
      if (Done) begin
        w_product_next    = r_acc[PW-1:0];
        w_prod_valid_next = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc        <= '0;
      r_mcand      <= '0;
      r_cnt        <= '0;
      r_product    <= '0;
      r_prod_valid <= 1'b0;
    end else begin
      r_acc        <= w_acc_next;
      r_mcand      <= w_mcand_next;
      r_cnt        <= w_cnt_next;
      r_product    <= w_product_next;
      r_prod_valid <= w_prod_valid_next;
    end
  end

  // Status back to CONTROL and result to the consumer.
  assign M         = r_acc[0];
  assign K         = w_cnt_last;
  assign Product   = r_product;
  assign ProdValid = r_prod_valid;

endmodule

// File: tb/tb_mult_datapath.sv
module tb_mult_datapath;

  localparam int W = 8;

  logic             Clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             Load = 1'b0;
  logic             Ad = 1'b0;
  logic             Sh = 1'b0;
  logic             Done = 1'b0;
  logic [W-1:0]     Mplier = '0;
  logic [W-1:0]     Mcand = '0;
  logic             M;
  logic             K;
  logic [2*W-1:0]   Product;
  logic             ProdValid;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  logic [2*W:0]   m_acc  = '0;
  logic [W-1:0]   m_mc   = '0;
  int             m_cnt  = 0;
  logic [2*W-1:0] m_prod = '0;
  logic           m_pv   = 1'b0;

  mult_datapath #(.WIDTH(W)) dut (
    .Clk(Clk), .reset_n(reset_n), .Load(Load), .Ad(Ad), .Sh(Sh), .Done(Done),
    .Mplier(Mplier), .Mcand(Mcand), .M(M), .K(K),
    .Product(Product), .ProdValid(ProdValid)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: multiplication as plain arithmetic on the accumulator value.
  always @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      m_acc = '0; m_mc = '0; m_cnt = 0; m_prod = '0; m_pv = 1'b0;
    end else if (Load) begin
      m_acc = (2*W+1)'(Mplier);
      m_mc  = Mcand;
      m_cnt = 0;
      m_pv  = 1'b0;
    end else begin
      if (Done) begin
        m_prod = m_acc[2*W-1:0];
        m_pv   = 1'b1;
      end
      if (Ad) m_acc = {1'b0, m_acc[2*W-1:0]} + ((2*W+1)'(m_mc) << W);
      if (Sh) begin
        m_acc = m_acc >> 1;
        m_cnt = (m_cnt + 1) % W;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("cmp_M", 32'(M), 32'(m_acc[0]));
      chk("cmp_K", 32'(K), 32'(m_cnt == W - 1));
      chk("cmp_Product", 32'(Product), 32'(m_prod));
      chk("cmp_ProdValid", 32'(ProdValid), 32'(m_pv));
      chk("cmp_acc", 32'(dut.r_acc), 32'(m_acc));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // CONTROL-like sequence; abort_bit >= 0 pulls reset during that bit.
  task automatic run_mult(input logic [W-1:0] mp, input logic [W-1:0] mc,
                          input int abort_bit, input bit m_zero,
                          input logic [2*W-1:0] exp_prod, input string nm);
    Mplier = mp; Mcand = mc; Load = 1'b1;
    tick();
    Load = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (m_zero) chk({nm, "_m_zero"}, 32'(M), 32'd0);
      Ad = m_acc[0];
      tick();
      Ad = 1'b0;
      if (i == abort_bit) begin
        #2;
        reset_n = 1'b0;
        #1;
        chk({nm, "_rst_M"}, 32'(M), 32'd0);
        chk({nm, "_rst_K"}, 32'(K), 32'd0);
        chk({nm, "_rst_Product"}, 32'(Product), 32'd0);
        chk({nm, "_rst_ProdValid"}, 32'(ProdValid), 32'd0);
        tick();
        reset_n = 1'b1;
        return;
      end
      chk({nm, "_K_shift"}, 32'(K), 32'(i == W - 1));
      Sh = 1'b1;
      tick();
      Sh = 1'b0;
    end
    Done = 1'b1;
    tick();
    Done = 1'b0;
    chk({nm, "_Product"}, 32'(Product), 32'(exp_prod));
    chk({nm, "_ProdValid"}, 32'(ProdValid), 32'd1);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("reset_M", 32'(M), 32'd0);
    chk("reset_K", 32'(K), 32'd0);
    chk("reset_Product", 32'(Product), 32'd0);
    chk("reset_ProdValid", 32'(ProdValid), 32'd0);
    cmp_en = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // 0x0B * 0x0D = 143
    run_mult(8'h0B, 8'h0D, -1, 1'b0, 16'h008F, "t1");

    // Load wins over Ad/Sh/Done in the same cycle
    Mplier = 8'h05; Mcand = 8'h07;
    Load = 1'b1; Ad = 1'b1; Sh = 1'b1; Done = 1'b1;
    tick();
    Load = 1'b0; Ad = 1'b0; Sh = 1'b0; Done = 1'b0;
    chk("t5_cnt", 32'(dut.r_cnt), 32'd0);
    chk("t5_ProdValid", 32'(ProdValid), 32'd0);
    chk("t5_Product_kept", 32'(Product), 32'h008F);
    chk("t5_acc", 32'(dut.r_acc), 32'h00005);
    tick();

    // Zero multiplier never adds
    run_mult(8'h00, 8'hA5, -1, 1'b1, 16'h0000, "t3");

    // 255 * 255 = 65025
    run_mult(8'hFF, 8'hFF, -1, 1'b0, 16'hFE01, "t2");

    // Reset during bit 4, then a clean 15 * 15 = 225
    run_mult(8'h0F, 8'h0F, 4, 1'b0, 16'h0000, "t4a");
    tick();
    run_mult(8'h0F, 8'h0F, -1, 1'b0, 16'h00E1, "t4b");

    // Ad and Sh together: add 3 then shift in one cycle
    Mplier = 8'h01; Mcand = 8'h03; Load = 1'b1;
    tick();
    Load = 1'b0; Ad = 1'b1; Sh = 1'b1;
    tick();
    Ad = 1'b0; Sh = 1'b0;
    chk("t6_acc", 32'(dut.r_acc), 32'h00180);
    chk("t6_cnt", 32'(dut.r_cnt), 32'd1);
    chk("t6_M", 32'(M), 32'd0);

    // Idle cycles must hold state
    tick();
    tick();
    chk("idle_acc", 32'(dut.r_acc), 32'h00180);
    chk("idle_cnt", 32'(dut.r_cnt), 32'd1);

    @(negedge Clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
